// File: rtl/hamming_serial_decoder.sv
// -----------------------------------------------------------------------------
// hamming_serial_decoder
//
// Serial receive-side decoder for the Hamming link. One code bit is sampled
// per clock while din_valid is high, and the bits are assembled LSB-first
// (code position 0 first) into 16-bit extended Hamming (16,11) frames. Each
// completed frame is decoded in the same cycle its last bit arrives. The
// 11 data bits and status flags are registered at that edge.
//
// Build option:
//   HAMMING_DED_EN  defined   -> extended SECDED. Position 0 carries overall
//                                even parity, and double errors are flagged.
//                   undefined -> plain SEC. Position 0 is received but
//                                ignored, err_double is always 0, and any
//                                nonzero syndrome is corrected.
//
// Ports:
//   clk           in   1   single clock, everything on posedge
//   rst           in   1   synchronous active-high reset, highest priority
//   datain        in   1   serial code bit
//   din_valid     in   1   datain/sync are sampled only when high
//   sync          in   1   (qualified by din_valid) current bit is position 0
//   dataout       out  11  decoded data, bit i = code position
//                          {3,5,6,7,9,10,11,12,13,14,15}[i]
//   out_valid     out  1   one-cycle pulse, dataout/flags/syndrome updated
//   err_corrected out  1   single error corrected (incl. position 0)
//   err_double    out  1   uncorrectable double error detected
//   syndrome      out  4   raw syndrome of the frame
//
// Handshake: there is no backpressure. The input side is valid-only, and a
// bit is consumed on every posedge where din_valid=1. The output side is
// valid-only, and out_valid pulses for exactly one cycle per completed frame.
// The registered data and flags then hold until the next pulse or reset.
// -----------------------------------------------------------------------------
module hamming_serial_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        datain,
    input  logic        din_valid,
    input  logic        sync,
    output logic [10:0] dataout,
    output logic        out_valid,
    output logic        err_corrected,
    output logic        err_double,
    output logic [3:0]  syndrome
);

    // Code positions that carry data. Entry k feeds dataout[k].
    localparam logic [3:0] DATA_POS [11] = '{
        4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15
    };

    // -------------------------------------------------------------------------
    // Accumulator
    // -------------------------------------------------------------------------
    // Only positions 1..14 are stored here. Position 15 is taken straight
    // from datain when the frame completes. Position 0 is stored only when
    // the parity bit is actually used.
    logic [3:0]  pos;
    logic [14:1] acc;
`ifdef HAMMING_DED_EN
    logic        bit0;
`endif

    logic frame_done;
    logic [15:1] code;

    // A sync on the position-15 sample restarts the frame instead of
    // completing it, so the frame is only emitted without sync.
    assign frame_done = din_valid && !sync && (pos == 4'd15);
    assign code       = {datain, acc};

    always_ff @(posedge clk) begin
        if (rst) begin
            pos <= 4'd0;
            acc <= '0;
`ifdef HAMMING_DED_EN
            bit0 <= 1'b0;
`endif
        end else if (din_valid) begin
            if (sync) begin
                // This bit becomes position 0, and any partial frame is dropped.
                pos <= 4'd1;
                acc <= '0;
`ifdef HAMMING_DED_EN
                bit0 <= datain;
`endif
            end else begin
                pos <= pos + 4'd1;
                for (int i = 1; i < 15; i++) begin
                    if (pos == 4'(i)) begin
                        acc[i] <= datain;
                    end
                end
`ifdef HAMMING_DED_EN
                if (pos == 4'd0) begin
                    bit0 <= datain;
                end
`endif
            end
        end
    end

    // -------------------------------------------------------------------------
    // Decode, combinational on the frame that completes this cycle
    // -------------------------------------------------------------------------
    logic [3:0]  dec_syn;
    logic [10:0] raw_data;
    logic [10:0] flip_mask;
    logic        do_flip;
    logic        dec_corr;
    logic        dec_double;
    logic [10:0] dec_data;
`ifdef HAMMING_DED_EN
    logic        parity;
`endif

    always_comb begin
        dec_syn    = 4'd0;
        raw_data   = '0;
        flip_mask  = '0;
        do_flip    = 1'b0;
        dec_corr   = 1'b0;
        dec_double = 1'b0;

        // The syndrome is the XOR of the indices of all set bits in positions 1..15.
        for (int i = 1; i < 16; i++) begin
            if (code[i]) begin
                dec_syn = dec_syn ^ 4'(i);
            end
        end

        for (int k = 0; k < 11; k++) begin
            raw_data[k] = code[DATA_POS[k]];
        end

`ifdef HAMMING_DED_EN
        parity = bit0 ^ (^code);
        if (dec_syn != 4'd0 && parity) begin
            do_flip  = 1'b1;
            dec_corr = 1'b1;
        end else if (dec_syn == 4'd0 && parity) begin
            // The parity bit itself is wrong, so the data is already good.
            dec_corr = 1'b1;
        end else if (dec_syn != 4'd0 && !parity) begin
            dec_double = 1'b1;
        end
`else
        if (dec_syn != 4'd0) begin
            do_flip  = 1'b1;
            dec_corr = 1'b1;
        end
`endif

        // A flip on a check position (1,2,4,8) matches no data entry and
        // leaves the data unchanged.
        if (do_flip) begin
            for (int k = 0; k < 11; k++) begin
                if (DATA_POS[k] == dec_syn) begin
                    flip_mask[k] = 1'b1;
                end
            end
        end

        dec_data = raw_data ^ flip_mask;
    end

    // -------------------------------------------------------------------------
    // Output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            dataout       <= '0;
            out_valid     <= 1'b0;
            err_corrected <= 1'b0;
            err_double    <= 1'b0;
            syndrome      <= 4'd0;
        end else begin
            out_valid <= frame_done;
            if (frame_done) begin
                dataout       <= dec_data;
                err_corrected <= dec_corr;
                err_double    <= dec_double;
                syndrome      <= dec_syn;
            end
        end
    end

endmodule

// File: doc/hamming_serial_decoder.md
# hamming_serial_decoder

Serial receive-side decoder for the Hamming link. It samples a bit stream one bit per enabled clock and assembles 16-bit extended Hamming (16,11) frames, bit position 0 first. Each completed frame is decoded with single-error correction and double-error detection, and the 11 data bits are presented with status flags. It sits directly downstream of the noise injector and closes the loop for the encoder → noise → decoder test chain.

## Interface
Parameters:
- none; frame length fixed at 16 bits (4-bit position counter).

Ports:
- clk  input  1  single clock; all logic on posedge clk.
- rst  input  1  synchronous, active-high reset.
- datain  input  1  serial code bit.
- din_valid  input  1  datain sampled on posedge clk only when high.
- sync  input  1  qualified by din_valid; marks the current bit as position 0 of a new frame.
- dataout  output  11  decoded data. Bit i = code position i-th of {3,5,6,7,9,10,11,12,13,14,15}.
- out_valid  output  1  one-cycle pulse; dataout and flags are valid.
- err_corrected  output  1  a single error was corrected (including position 0).
- err_double  output  1  an uncorrectable double error was detected.
- syndrome  output  4  raw syndrome of the frame.

## Operation
- Position counter pos[3:0]:
  - Reset value 0; increments on each sampled bit and wraps 15→0.
  - A sampled bit with sync=1 is written at position 0 and sets pos to 1; any partial frame is discarded.
- Bits accumulate in a 16-bit frame register at index pos.
- When the bit at pos=15 is sampled, the full frame moves to the decode stage. The accumulator immediately accepts the next frame's position 0, so back-to-back frames need no gap.
- Decode, combinational on the captured frame:
  - s = XOR of the indices i in 1..15 whose bit is 1.
  - p = XOR of all 16 bits (even parity).
- Outcomes with DED compiled in:
  - s=0, p=0: no error; flags 0.
  - s≠0, p=1: flip bit s; err_corrected=1.
  - s=0, p=1: bit 0 in error; data unchanged; err_corrected=1.
  - s≠0, p=0: err_double=1, err_corrected=0; dataout is the uncorrected data.
- Flags are mutually exclusive.
- din_valid low: no state change, pos holds.
- rst: pos, frame register and all outputs clear; the in-flight frame is dropped and no out_valid is produced for it.
- rst has priority over sync and din_valid.

## Timing
- Reset values: dataout=0, out_valid=0, err_corrected=0, err_double=0, syndrome=0.
- Latency: out_valid is high in the cycle after the posedge that samples position 15. dataout, flags and syndrome are registered at that same edge.
- dataout, flags and syndrome hold until the next out_valid, or until rst.
- Maximum throughput: one frame per 16 cycles with din_valid held high.
- sync at pos=0 is legal and has no extra effect.
- sync together with the position-15 sample: sync wins, and the frame is not emitted.

## Configuration
- HAMMING_DED_EN defined: extended SECDED as above.
- HAMMING_DED_EN undefined:
  - Position 0 is received but ignored; p is not computed; err_double is tied to 0.
  - s≠0 always flips bit s and sets err_corrected.
  - Double errors are therefore miscorrected.

## Test plan
- All-zero frame, no errors → out_valid one cycle after bit 15; dataout=11'h000, syndrome=0, flags 0.
- All-zero frame with position 5 flipped → syndrome=5, err_corrected=1, dataout=11'h000.
- All-ones frame with position 0 flipped → syndrome=0, err_corrected=1, dataout=11'h7FF.
- All-ones frame with positions 3 and 10 flipped, DED on → syndrome=9, err_double=1, err_corrected=0, dataout=11'h7DE.
- Same error pattern on an all-zero frame, DED off → syndrome=9, err_corrected=1, dataout=11'h031 (miscorrection).
- Sequence: rst after 7 bits, then a full all-ones frame, then sync asserted at bit 9 of the next frame, then a clean frame → exactly one out_valid with 11'h7FF before the resync and one with the clean frame's data after it; no output for the aborted frames.
